// File: rtl/vip_raw_decode_pkg.sv
// vrdecode_defs: shared constants and types for the VIP -> raw stream decoder.
// Packet type codes, control-packet nibble count, FSM state encodings.
package vrdecode_defs;

    localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;
    localparam logic [3:0] VIP_PKT_CTRL  = 4'hF;
    localparam logic [3:0] CTRL_NIBBLES  = 4'd9;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CTRL    = 2'd1;
    localparam logic [1:0] ST_VIDEO   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Nine captured nibbles, oldest first: width, height, interlace.
    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [3:0]  interlaced;
    } vip_ctrl_t;

endpackage

// File: rtl/vip_raw_decode_if.sv
// vip_raw_decode_if: Avalon-ST bundle (data/valid/sop/eop/ready).
// master drives data/valid/sop/eop and samples ready; slave is the reverse.
interface vip_raw_decode_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  ready;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/vip_raw_decode_ctrl_parse.sv
// vrdecode_ctrl_parse: captures the 9 control nibbles and commits im_*.
// In: clk, rst_n, start (header seen), beat (ctrl payload beat), eop, nibble.
// Out: im_width, im_height, im_interlaced, ctrl_update (1-cycle pulse).
module vrdecode_ctrl_parse
    import vrdecode_defs::*;
#(
    parameter logic [15:0] VIP_WIDTH      = 16'd720,
    parameter logic [15:0] VIP_HEIGHT     = 16'd576,
    parameter logic [3:0]  VIP_INTERLACED = 4'b0010
) (
    input  logic        vst_clk,
    input  logic        vst_rst_n,
    input  logic        start,
    input  logic        beat,
    input  logic        eop,
    input  logic [3:0]  nibble,
    output logic [15:0] im_width,
    output logic [15:0] im_height,
    output logic [3:0]  im_interlaced,
    output logic        ctrl_update
);

    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [35:0] sh;
    logic [35:0] sh_nx;
    logic        cap;
    logic        commit;
    vip_ctrl_t   fld;

    // Beats past the ninth nibble are ignored; the EOP beat itself may be
    // the ninth capture, so completeness is judged on the next count.
    always_comb begin
        cap    = beat && (cnt < CTRL_NIBBLES);
        cnt_nx = cap ? cnt + 4'd1 : cnt;
        sh_nx  = cap ? {sh[31:0], nibble} : sh;
        commit = beat && eop && (cnt_nx == CTRL_NIBBLES);
        fld    = sh_nx;
    end

    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            cnt           <= '0;
            sh            <= '0;
            im_width      <= VIP_WIDTH;
            im_height     <= VIP_HEIGHT;
            im_interlaced <= VIP_INTERLACED;
            ctrl_update   <= 1'b0;
        end else begin
            ctrl_update <= commit;
            if (start) begin
                cnt <= '0;
            end else if (cap) begin
                cnt <= cnt_nx;
                sh  <= sh_nx;
            end
            if (commit) begin
                im_width      <= fld.width;
                im_height     <= fld.height;
                im_interlaced <= fld.interlaced;
            end
        end
    end

endmodule

// File: rtl/vip_raw_decode.sv
// vip_raw_decode: VIP Avalon-ST in (din) -> raw SOP/EOP pixel stream (raw).
// Ports: vst_clk, vst_rst_n, din (slave), raw (master), im_width/height/
// interlaced, ctrl_update, frame_err (only with PIXEL_CHECK_EN defined).
module vip_raw_decode
    import vrdecode_defs::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter int          DATA_BITS      = 8,
    parameter logic [15:0] VIP_WIDTH      = 16'd720,
    parameter logic [15:0] VIP_HEIGHT     = 16'd576,
    parameter logic [3:0]  VIP_INTERLACED = 4'b0010
) (
    input  logic               vst_clk,
    input  logic               vst_rst_n,
    vip_raw_decode_if.slave    din,
    vip_raw_decode_if.master   raw,
    output logic [15:0]        im_width,
    output logic [15:0]        im_height,
    output logic [3:0]         im_interlaced,
    output logic               ctrl_update
`ifdef PIXEL_CHECK_EN
    ,
    output logic               frame_err
`endif
);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] nib;
    logic       acc;
    logic       hdr;
    logic       body;
    logic       fwd;
    logic       load;
    logic       first;

    // Control nibble and packet type live in the low bits of symbol 0.
    assign nib  = 4'(din.data[DATA_BITS-1:0]);
    assign load = !raw.valid || raw.ready;

    assign din.ready = (state != ST_VIDEO) || load;

    assign acc  = din.valid && din.ready;
    assign hdr  = acc && din.startofpacket;
    assign body = acc && !din.startofpacket;
    assign fwd  = body && (state == ST_VIDEO);

    // Any SOP is a header, whatever state we are in; that is also
    // how a packet in flight gets aborted.
    always_comb begin
        state_nx = state;
        if (hdr) begin
            if (din.endofpacket)
                state_nx = ST_IDLE;
            else if (nib == VIP_PKT_CTRL)
                state_nx = ST_CTRL;
            else if (nib == VIP_PKT_VIDEO)
                state_nx = ST_VIDEO;
            else
                state_nx = ST_DISCARD;
        end else if (body && din.endofpacket) begin
            state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            state <= ST_IDLE;
            first <= 1'b0;
        end else begin
            state <= state_nx;
            if (hdr)
                first <= 1'b1;
            else if (fwd)
                first <= 1'b0;
        end
    end

    // Single output register; in VIDEO din is only accepted when it can load.
    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            raw.valid         <= 1'b0;
            raw.startofpacket <= 1'b0;
            raw.endofpacket   <= 1'b0;
            raw.data          <= '0;
        end else if (load) begin
            raw.valid         <= fwd;
            raw.startofpacket <= fwd && first;
            raw.endofpacket   <= fwd && din.endofpacket;
            if (fwd)
                raw.data <= din.data;
        end
    end

    vrdecode_ctrl_parse #(
        .VIP_WIDTH      (VIP_WIDTH),
        .VIP_HEIGHT     (VIP_HEIGHT),
        .VIP_INTERLACED (VIP_INTERLACED)
    ) u_ctrl (
        .vst_clk       (vst_clk),
        .vst_rst_n     (vst_rst_n),
        .start         (hdr),
        .beat          (body && (state == ST_CTRL)),
        .eop           (din.endofpacket),
        .nibble        (nib),
        .im_width      (im_width),
        .im_height     (im_height),
        .im_interlaced (im_interlaced),
        .ctrl_update   (ctrl_update)
    );

`ifdef PIXEL_CHECK_EN
    logic [31:0] pix_cnt;
    logic [31:0] pix_exp;
    logic [31:0] pix_cnt_nx;

    assign pix_exp    = {16'd0, im_width} * {16'd0, im_height};
    assign pix_cnt_nx = pix_cnt + 32'd1;

    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            pix_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (hdr)
                pix_cnt <= '0;
            else if (fwd)
                pix_cnt <= pix_cnt_nx;
            frame_err <= (fwd && din.endofpacket && (pix_cnt_nx != pix_exp))
                       || (hdr && (state == ST_VIDEO));
        end
    end
`endif

endmodule

// File: tb/tb_vip_raw_decode.sv
// tb_vip_raw_decode: directed + random packets against a packet-level model.
// Define PIXEL_CHECK_EN to also exercise frame_err.
module tb_vip_raw_decode;
    import vrdecode_defs::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vip_raw_decode_if #(.DATA_WIDTH(DW)) din_if ();
    vip_raw_decode_if #(.DATA_WIDTH(DW)) raw_if ();

    logic [15:0] im_width;
    logic [15:0] im_height;
    logic [3:0]  im_interlaced;
    logic        ctrl_update;
`ifdef PIXEL_CHECK_EN
    logic        frame_err;
`endif

    vip_raw_decode dut (
        .vst_clk       (clk),
        .vst_rst_n     (rst_n),
        .din           (din_if),
        .raw           (raw_if),
        .im_width      (im_width),
        .im_height     (im_height),
        .im_interlaced (im_interlaced),
        .ctrl_update   (ctrl_update)
`ifdef PIXEL_CHECK_EN
        ,
        .frame_err     (frame_err)
`endif
    );

    typedef logic [DW+1:0] beat_t;

    int nchk = 0;
    int nfail = 0;
    beat_t expq[$];
    beat_t gotq[$];
    logic [15:0] m_w = 16'd720;
    logic [15:0] m_h = 16'd576;
    logic [3:0]  m_i = 4'd2;
    int n_cu = 0;
    int exp_cu = 0;
    int n_fe = 0;
    int exp_fe = 0;
    bit video_f = 1'b0;
    bit rnd_rdy = 1'b0;
    int stalls = 0;
    logic [7:0] pay [64];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (raw_if.valid && raw_if.ready)
                gotq.push_back({raw_if.startofpacket, raw_if.endofpacket,
                                raw_if.data});
            if (ctrl_update)
                n_cu++;
`ifdef PIXEL_CHECK_EN
            if (frame_err)
                n_fe++;
`endif
            if (video_f)
                chk("din_ready_bp", din_if.ready,
                    !raw_if.valid || raw_if.ready);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            raw_if.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit sop,
                             input bit eop, input bit gaps);
        int w = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            din_if.valid = 1'b0;
            @(posedge clk);
            #1;
        end
        din_if.data          = d;
        din_if.startofpacket = sop;
        din_if.endofpacket   = eop;
        din_if.valid         = 1'b1;
        forever begin
            @(negedge clk);
            if (din_if.ready)
                break;
            w++;
            if (w > 200) begin
                nchk++;
                nfail++;
                $error("FAIL din_ready_timeout: got 0 expected 1");
                break;
            end
        end
        stalls += w;
        @(posedge clk);
        #1;
        din_if.valid         = 1'b0;
        din_if.startofpacket = 1'b0;
        din_if.endofpacket   = 1'b0;
    endtask

    // Packet-level model: header + n payload beats from pay[]; an aborted
    // packet ends without EOP and must be followed by another header.
    task automatic send_pkt(input logic [3:0] typ, input int n,
                            input bit abort, input bit gaps, input bit lat);
        bit hdr_eop = (n == 0) && !abort;
        logic [31:0] area;
        send_beat({4'($urandom), typ}, 1'b1, hdr_eop, gaps);
        video_f = (typ == VIP_PKT_VIDEO) && !hdr_eop;
        for (int i = 0; i < n; i++) begin
            bit e = (i == n - 1) && !abort;
            send_beat(pay[i], 1'b0, e, gaps);
            if (typ == VIP_PKT_VIDEO) begin
                expq.push_back({i == 0, e, pay[i]});
                if (lat) begin
                    #3;
                    chk("lat_valid", raw_if.valid, 1'b1);
                    chk("lat_data", raw_if.data, pay[i]);
                    chk("lat_sop", raw_if.startofpacket, i == 0);
                    chk("lat_eop", raw_if.endofpacket, e);
                end
            end
        end
        if (!abort)
            video_f = 1'b0;
        if (typ == VIP_PKT_CTRL && !abort && n >= 9) begin
            m_w = {pay[0][3:0], pay[1][3:0], pay[2][3:0], pay[3][3:0]};
            m_h = {pay[4][3:0], pay[5][3:0], pay[6][3:0], pay[7][3:0]};
            m_i = pay[8][3:0];
            exp_cu++;
        end
        area = {16'd0, m_w} * {16'd0, m_h};
        if (typ == VIP_PKT_VIDEO && (abort || n > 0)) begin
            if (abort || area != 32'(n))
                exp_fe++;
        end
    endtask

    task automatic check_raw(input string tag);
        int w = 0;
        while (gotq.size() < expq.size() && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_count"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            chk({tag, "_beat"}, gotq[i], expq[i]);
        gotq.delete();
        expq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_im(input string tag);
        chk({tag, "_w"}, im_width, m_w);
        chk({tag, "_h"}, im_height, m_h);
        chk({tag, "_i"}, im_interlaced, m_i);
    endtask

    task automatic set_nibs(input logic [15:0] w, input logic [15:0] h,
                            input logic [3:0] il);
        logic [35:0] v = {w, h, il};
        for (int i = 0; i < 9; i++)
            pay[i] = {4'($urandom), v[35-4*i -: 4]};
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        din_if.data          = '0;
        din_if.valid         = 1'b0;
        din_if.startofpacket = 1'b0;
        din_if.endofpacket   = 1'b0;
        raw_if.ready         = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", raw_if.valid, 1'b0);
        chk("rst_sop", raw_if.startofpacket, 1'b0);
        chk("rst_eop", raw_if.endofpacket, 1'b0);
        chk("rst_data", raw_if.data, 8'h00);
        chk("rst_cu", ctrl_update, 1'b0);
        chk("rst_ready", din_if.ready, 1'b1);
        check_im("rst_im");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: default-valued control packet, then a distinct one
        set_nibs(16'd720, 16'd576, 4'd2);
        send_pkt(VIP_PKT_CTRL, 9, 1'b0, 1'b0, 1'b0);
        #3;
        chk("t1_cu_hi", ctrl_update, 1'b1);
        check_im("t1_im");
        #10;
        chk("t1_cu_lo", ctrl_update, 1'b0);
        set_nibs(16'h1234, 16'h0056, 4'h9);
        send_pkt(VIP_PKT_CTRL, 9, 1'b0, 1'b0, 1'b0);
        #3;
        chk("t1b_cu_hi", ctrl_update, 1'b1);
        check_im("t1b_im");

        // 2: 16 pixels, raw_ready held high, 1-cycle latency
        for (int i = 0; i < 16; i++)
            pay[i] = 8'(i + 1);
        send_pkt(VIP_PKT_VIDEO, 16, 1'b0, 1'b0, 1'b1);
        check_raw("t2");

        // 3: same pixels under random backpressure
        rnd_rdy = 1'b1;
        send_pkt(VIP_PKT_VIDEO, 16, 1'b0, 1'b1, 1'b0);
        check_raw("t3");
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;

        // 4: short control packet, then a discarded type-3 packet
        for (int i = 0; i < 5; i++)
            pay[i] = 8'($urandom);
        send_pkt(VIP_PKT_CTRL, 5, 1'b0, 1'b0, 1'b0);
        stalls = 0;
        for (int i = 0; i < 10; i++)
            pay[i] = 8'($urandom);
        send_pkt(4'h3, 10, 1'b0, 1'b0, 1'b0);
        chk("t4_no_stall", stalls, 0);
        check_raw("t4");
        check_im("t4_im");
        chk("t4_cu_cnt", n_cu, exp_cu);

        // 5: video aborted after 7 pixels, then a 4x2 control packet
        for (int i = 0; i < 7; i++)
            pay[i] = 8'($urandom);
        send_pkt(VIP_PKT_VIDEO, 7, 1'b1, 1'b0, 1'b0);
        set_nibs(16'd4, 16'd2, 4'd0);
        send_pkt(VIP_PKT_CTRL, 9, 1'b0, 1'b0, 1'b0);
        check_raw("t5");
        check_im("t5_im");
        chk("t5_cu_cnt", n_cu, exp_cu);

        // 6: exact-size frame, then one pixel too many
        for (int i = 0; i < 9; i++)
            pay[i] = 8'($urandom);
        send_pkt(VIP_PKT_VIDEO, 8, 1'b0, 1'b0, 1'b0);
`ifdef PIXEL_CHECK_EN
        #3;
        chk("t6_ok_fe", frame_err, 1'b0);
`endif
        send_pkt(VIP_PKT_VIDEO, 9, 1'b0, 1'b0, 1'b0);
`ifdef PIXEL_CHECK_EN
        #3;
        chk("t6_bad_fe", frame_err, 1'b1);
`endif
        check_raw("t6");
`ifdef PIXEL_CHECK_EN
        chk("t6_fe_cnt", n_fe, exp_fe);
`endif

        // Reset in the middle of a video packet, then stray beats
        send_beat(8'h50, 1'b1, 1'b0, 1'b0);
        video_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
            expq.push_back({i == 0, 1'b0, 8'(8'hA0 + i)});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        video_f = 1'b0;
        #3;
        chk("mrst_valid", raw_if.valid, 1'b0);
        chk("mrst_data", raw_if.data, 8'h00);
        m_w = 16'd720;
        m_h = 16'd576;
        m_i = 4'd2;
        check_im("mrst_im");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            send_beat(8'($urandom), 1'b0, i == 2, 1'b0);
        check_raw("mrst");

        // Random packet mix under random backpressure and input gaps
        rnd_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int sel = $urandom_range(0, 3);
            logic [3:0] typ;
            int n;
            bit ab;
            typ = (sel == 1) ? VIP_PKT_CTRL :
                  (sel == 2) ? 4'($urandom_range(1, 14)) : VIP_PKT_VIDEO;
            n  = (typ == VIP_PKT_CTRL) ? $urandom_range(5, 12)
                                       : $urandom_range(1, 20);
            if ($urandom_range(0, 9) == 0)
                n = 0;
            ab = (k != 39) && ($urandom_range(0, 4) == 0);
            for (int i = 0; i < n; i++)
                pay[i] = 8'($urandom);
            send_pkt(typ, n, ab, 1'b1, 1'b0);
        end
        check_raw("rnd");
        check_im("rnd_im");
        chk("rnd_cu_cnt", n_cu, exp_cu);
`ifdef PIXEL_CHECK_EN
        chk("rnd_fe_cnt", n_fe, exp_fe);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
